// File: rtl/atpg_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : atpg_bist_ctrl
// Description : Self-sequencing BIST controller for a combinational
//               circuit-under-test (CUT).
//               - A 16-bit LFSR produces pseudo-random patterns that drive
//                 the CUT primary inputs.
//               - The CUT primary outputs are folded into a 16-bit MISR.
//               - After PATTERNS captures, the MISR is compared against a
//                 golden signature to give a single pass/fail result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_PI      CUT primary-input count, 1..16
//   N_PO      CUT primary-output count, 1..16
//   PATTERNS  patterns per run, 1..65535
//   SEED      LFSR seed (0 is replaced by 16'h0001)
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start_i      begin a run (honoured in IDLE or DONE only)
//   step_en_i    1 = single-step mode
//   step_i       single-step advance from APPLY to CAPTURE
//   golden_i     expected signature, sampled in COMPARE
//   resp_in_i    CUT outputs, sampled only in CAPTURE
//   pat_out_o    CUT inputs
//   busy_o       high in LOAD, APPLY, CAPTURE and COMPARE
//   done_o       high in DONE
//   pass_o       signature matched golden; valid while done_o = 1
//   signature_o  MISR contents
//   pat_cnt_o    number of patterns captured so far
// ============================================================================
module atpg_bist_ctrl #(
  parameter int unsigned N_PI     = 7,
  parameter int unsigned N_PO     = 4,
  parameter int unsigned PATTERNS = 256,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_en_i,
  input  logic            step_i,
  input  logic [15:0]     golden_i,
  input  logic [N_PO-1:0] resp_in_i,
  output logic [N_PI-1:0] pat_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [15:0]     signature_o,
  output logic [15:0]     pat_cnt_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [15:0] c_SEED     = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // Count value seen during the final capture of a run.
  localparam logic [15:0] c_LAST_CNT = 16'(PATTERNS - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] misr_q;
  logic [15:0] misr_d;
  logic [15:0] pat_cnt_q;
  logic [15:0] pat_cnt_d;
  logic        pass_q;
  logic        pass_d;

  logic        fbl_w;
  logic        fbm_w;
  logic        last_pat_w;
  logic [15:0] resp_ext_w;

  // --------------------------------------------------------------------------
  // Feedback taps (bits 15, 13, 12, 10) shared by the LFSR and the MISR
  // --------------------------------------------------------------------------
  assign fbl_w      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign fbm_w      = misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10];
  assign last_pat_w = (pat_cnt_q == c_LAST_CNT);

  // Response is zero-extended into the low bits of the MISR input.
  generate
    if (N_PO < 16) begin : g_resp_pad
      assign resp_ext_w = {{(16 - N_PO){1'b0}}, resp_in_i};
    end else begin : g_resp_full
      assign resp_ext_w = resp_in_i;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_APPLY;
      end
      S_APPLY: begin
        // In single-step mode the CUT inputs are held until step is seen.
        if (!step_en_i || step_i) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = last_pat_w ? S_COMPARE : S_APPLY;
      end
      S_COMPARE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    pat_out_o = '0;
    case (state_q)
      S_LOAD, S_COMPARE: begin
        busy_o = 1'b1;
      end
      S_APPLY, S_CAPTURE: begin
        // The LFSR only advances on the CAPTURE edge, so the pattern stays
        // stable across both cycles of a pattern.
        busy_o    = 1'b1;
        pat_out_o = lfsr_q[N_PI-1:0];
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: next-state values for LFSR, MISR, counter and verdict
  // --------------------------------------------------------------------------
  always_comb begin
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    pat_cnt_d = pat_cnt_q;
    pass_d    = pass_q;
    case (state_q)
      S_LOAD: begin
        lfsr_d    = c_SEED;
        misr_d    = '0;
        pat_cnt_d = '0;
        pass_d    = 1'b0;
      end
      S_CAPTURE: begin
        lfsr_d    = {lfsr_q[14:0], fbl_w};
        misr_d    = {misr_q[14:0], fbm_w} ^ resp_ext_w;
        pat_cnt_d = pat_cnt_q + 16'd1;
      end
      S_COMPARE: begin
        pass_d = (misr_q == golden_i);
      end
      default: begin
        pass_d = pass_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= c_SEED;
      misr_q    <= '0;
      pat_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      pat_cnt_q <= pat_cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign signature_o = misr_q;
  assign pat_cnt_o   = pat_cnt_q;
  assign pass_o      = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_atpg_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_atpg_bist_ctrl
// Description : Self-checking bench for atpg_bist_ctrl (N_PI=7, N_PO=4,
//               PATTERNS=4). Expected patterns and signatures come from a
//               reference model of the LFSR/MISR rules kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atpg_bist_ctrl;

  localparam int          P       = 4;
  localparam logic [15:0] SEED_TB = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        step_en_i;
  logic        step_i;
  logic [15:0] golden_i;
  logic [3:0]  resp_in_i;
  logic [6:0]  pat_out_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] signature_o;
  logic [15:0] pat_cnt_o;

  int          nerr = 0;
  int          nchk = 0;
  logic [3:0]  resp_hist [P];
  logic [15:0] sig_a;
  logic [15:0] sig_b;

  atpg_bist_ctrl #(
    .N_PI     (7),
    .N_PO     (4),
    .PATTERNS (P),
    .SEED     (SEED_TB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .step_en_i   (step_en_i),
    .step_i      (step_i),
    .golden_i    (golden_i),
    .resp_in_i   (resp_in_i),
    .pat_out_o   (pat_out_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .signature_o (signature_o),
    .pat_cnt_o   (pat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift-left-with-parity step: parity of the tap bits 15,13,12,10 enters bit 0.
  function automatic logic [15:0] step16(input logic [15:0] x);
    logic [15:0] taps;
    taps = x & 16'hB400;
    return 16'((32'(x) * 2) % 65536) | 16'($countones(taps) % 2);
  endfunction

  // resp_mode: 0 = all-zero response, 1 = random, 2 = replay previous run
  // step_mode: 0 = free-running, 1 = single-step, 2 = random per pattern
  task automatic run_bist(input int resp_mode, input int step_mode,
                          input bit gold_match, input logic [15:0] gold_val,
                          output logic [15:0] sig);
    logic [15:0] m_lfsr;
    logic [15:0] m_misr;
    logic [3:0]  r;
    logic        se;
    int          k;
    golden_i = gold_val;
    start_i  = 1'b1;
    tick();                                  // LOAD
    start_i  = 1'b0;
    chk("load_busy", 32'(busy_o), 32'd1);
    chk("load_done", 32'(done_o), 32'd0);
    chk("load_patout", 32'(pat_out_o), 32'd0);
    m_lfsr = SEED_TB;
    m_misr = 16'h0000;
    tick();                                  // APPLY, pattern 0
    for (int p = 0; p < P; p++) begin
      step_i    = 1'b0;
      se        = (step_mode == 0) ? 1'b0 :
                  (step_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      step_en_i = se;
      chk("apply_patout", 32'(pat_out_o), 32'(m_lfsr[6:0]));
      chk("apply_cnt", 32'(pat_cnt_o), 32'(p));
      chk("apply_busy", 32'(busy_o), 32'd1);
      resp_in_i = 4'($urandom);              // not sampled outside CAPTURE
      start_i   = 1'($urandom_range(0, 1));  // ignored while busy
      if (se) begin
        k = (p == 0) ? 5 : $urandom_range(0, 3);
        for (int w = 0; w < k; w++) begin
          tick();
          chk("step_hold_cnt", 32'(pat_cnt_o), 32'(p));
          chk("step_hold_pat", 32'(pat_out_o), 32'(m_lfsr[6:0]));
          resp_in_i = 4'($urandom);
        end
        step_i = 1'b1;
      end
      tick();                                // CAPTURE
      start_i = 1'b0;
      step_i  = 1'($urandom_range(0, 1));    // no effect in CAPTURE
      chk("cap_patout", 32'(pat_out_o), 32'(m_lfsr[6:0]));
      chk("cap_cnt", 32'(pat_cnt_o), 32'(p));
      r = (resp_mode == 0) ? 4'h0 : (resp_mode == 2) ? resp_hist[p] : 4'($urandom);
      resp_hist[p] = r;
      resp_in_i    = r;
      tick();                                // APPLY of next pattern or COMPARE
      m_misr = step16(m_misr) ^ {12'h000, r};
      m_lfsr = step16(m_lfsr);
      chk("sig_after_cap", 32'(signature_o), 32'(m_misr));
      chk("cnt_after_cap", 32'(pat_cnt_o), 32'(p + 1));
    end
    step_i = 1'b0;
    // COMPARE
    chk("cmp_busy", 32'(busy_o), 32'd1);
    chk("cmp_done", 32'(done_o), 32'd0);
    chk("cmp_patout", 32'(pat_out_o), 32'd0);
    if (gold_match) golden_i = m_misr;
    resp_in_i = 4'($urandom);
    tick();                                  // DONE
    chk("done_flag", 32'(done_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_pass", 32'(pass_o), 32'(m_misr == golden_i));
    chk("done_sig", 32'(signature_o), 32'(m_misr));
    chk("done_cnt", 32'(pat_cnt_o), 32'(P));
    chk("done_patout", 32'(pat_out_o), 32'd0);
    // DONE holds its results; step and response changes have no effect.
    step_i    = 1'b1;
    resp_in_i = 4'($urandom);
    tick();
    tick();
    step_i = 1'b0;
    chk("hold_done", 32'(done_o), 32'd1);
    chk("hold_sig", 32'(signature_o), 32'(m_misr));
    chk("hold_pass", 32'(pass_o), 32'(m_misr == golden_i));
    chk("hold_cnt", 32'(pat_cnt_o), 32'(P));
    sig = m_misr;
  endtask

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    step_en_i = 1'b0;
    step_i    = 1'b0;
    golden_i  = 16'h0000;
    resp_in_i = 4'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_patout", 32'(pat_out_o), 32'd0);
    chk("rst_sig", 32'(signature_o), 32'd0);
    chk("rst_cnt", 32'(pat_cnt_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Zero response, golden 0 -> pass; then golden 1 -> fail.
    run_bist(0, 0, 1'b0, 16'h0000, sig_a);
    chk("zero_sig", 32'(signature_o), 32'd0);
    chk("zero_pass", 32'(pass_o), 32'd1);
    run_bist(0, 0, 1'b0, 16'h0001, sig_a);
    chk("gold1_pass", 32'(pass_o), 32'd0);
    chk("gold1_done", 32'(done_o), 32'd1);

    // Random response with matching golden, then replay from DONE.
    run_bist(1, 0, 1'b1, 16'h0000, sig_a);
    run_bist(2, 0, 1'b0, 16'h0000, sig_b);
    chk("rerun_sig", 32'(signature_o), 32'(sig_a));
    chk("rerun_pass", 32'(pass_o), 32'(sig_a == 16'h0000));

    // Single-step and mixed-step runs.
    run_bist(1, 1, 1'b0, 16'($urandom), sig_a);
    run_bist(1, 2, 1'b1, 16'h0000, sig_a);

    // Reset in the middle of pattern 2.
    step_en_i = 1'b0;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    resp_in_i = 4'hF;
    for (int c = 0; c < 5; c++) tick();
    chk("mid_cnt", 32'(pat_cnt_o), 32'd2);
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_done", 32'(done_o), 32'd0);
    chk("mrst_patout", 32'(pat_out_o), 32'd0);
    chk("mrst_sig", 32'(signature_o), 32'd0);
    chk("mrst_cnt", 32'(pat_cnt_o), 32'd0);
    chk("mrst_pass", 32'(pass_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_idle", 32'(busy_o), 32'd0);
    run_bist(1, 0, 1'b1, 16'h0000, sig_a);

    // A few fully random runs.
    for (int i = 0; i < 4; i++) begin
      run_bist(1, 2, 1'($urandom_range(0, 1)), 16'($urandom), sig_a);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atpg_bist_ctrl.md
# atpg_bist_ctrl

Parametrised built-in self-test controller for the ATPG test circuits. It drives the primary inputs of an external combinational circuit-under-test (CUT) with LFSR pseudo-random patterns and compacts the CUT primary outputs into a MISR signature. At the end of a run it compares the signature against a golden value to give a single pass/fail. It is the generalised, self-sequencing successor of the fixed 7-input/4-output fault-free netlists, so fault-free and faulty netlists can be screened on-chip.

## Interface
- N_PI, 7, CUT primary-input count; 1..16.
- N_PO, 4, CUT primary-output count; 1..16.
- PATTERNS, 256, number of patterns per run; 1..65535.
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a run when sampled in IDLE or DONE.
- step_en  in  1  1 = single-step mode.
- step  in  1  in single-step mode, advances APPLY→CAPTURE.
- golden  in  16  expected signature; sampled in COMPARE.
- resp_in  in  N_PO  CUT outputs; sampled only in CAPTURE.
- pat_out  out  N_PI  CUT inputs.
- busy  out  1  high in LOAD, APPLY, CAPTURE and COMPARE.
- done  out  1  high in DONE.
- pass  out  1  signature == golden; valid while done = 1.
- signature  out  16  MISR contents.
- pat_cnt  out  16  number of patterns captured so far.

## Operation
- States: IDLE, LOAD, APPLY, CAPTURE, COMPARE, DONE.
- Reset:
  - state = IDLE; lfsr = SEED (after the zero substitution).
  - misr = 0, pat_cnt = 0, pass = 0, done = 0, busy = 0, pat_out = 0.
- IDLE or DONE, start = 1 → LOAD. start in any other state is ignored.
- LOAD: lfsr ← SEED, misr ← 0, pat_cnt ← 0, pass ← 0; → APPLY.
- APPLY:
  - pat_out = lfsr[N_PI-1:0]; the CUT settles during this cycle.
  - → CAPTURE unconditionally when step_en = 0.
  - When step_en = 1, → CAPTURE only in a cycle with step = 1; otherwise stay in APPLY.
- CAPTURE:
  - pat_out is held.
  - misr ← {misr[14:0], fbm} XOR zero-extended resp_in, where fbm = misr[15]^misr[13]^misr[12]^misr[10].
  - lfsr ← {lfsr[14:0], fbl}, where fbl = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - pat_cnt ← pat_cnt + 1.
  - If pat_cnt == PATTERNS-1 before the increment → COMPARE; else → APPLY.
- COMPARE: pass ← (misr == golden); → DONE.
- DONE: done = 1; signature, pass and pat_cnt are held until the next start or rst.
- pat_out = 0 in IDLE, LOAD, COMPARE and DONE.
- signature always reflects misr.

## Timing
- Start sampled at edge t:
  - LOAD at t, APPLY from t+1.
  - Captures happen at edges t+3, t+5, …, t+2·PATTERNS+1.
  - done rises at edge t+2·PATTERNS+2.
- The CUT has one full cycle (the APPLY cycle) plus the CAPTURE cycle before sampling, so the combinational CUT path must be under 2 cycles.
- Single-step: each pattern takes 1 + k cycles, where k is the wait until step is seen. step in a non-APPLY state has no effect.
- rst mid-run takes priority over every transition and returns all outputs to their reset values on the next edge.
- start and step together in APPLY: start is ignored.
- step_en toggled mid-run takes effect at the next APPLY cycle.
- pat_cnt wraps at 16 bits but is bounded by PATTERNS ≤ 65535, so no wrap occurs in normal use.

## Test plan
- Reset, then start with step_en = 0, N_PI = 7 → pat_out = 7'h61 during pattern 0 and 7'h43 during pattern 1 (lfsr 16'hACE1 → 16'h59C3).
- resp_in tied to 0, PATTERNS = 4, golden = 0 → done rises 10 edges after start; signature = 0, pass = 1, pat_cnt = 4.
- Same run with golden = 16'h0001 → pass = 0, done = 1.
- step_en = 1, step held low for 5 cycles → state stays APPLY and pat_cnt stays 0. One step pulse → exactly one capture, pat_cnt = 1.
- rst asserted at pattern 2 of 4 → next edge: busy = 0, done = 0, pat_out = 0, signature = 0. A new start completes normally.
- start pulsed while busy → ignored. start pulsed in DONE → rerun, and an identical resp_in stream gives an identical signature.
